ascon_fsm: RTL and testbench



---
 rtl/ascon_pkg.sv | 25 ++
 rtl/ascon_round_counter.sv | 27 ++
 rtl/ascon_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_ascon_fsm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and round constants for the ASCON-128 control path.
package ascon_pkg;

  localparam int ROUND_WIDTH   = 4;
  localparam int ROUNDS_A      = 12;
  localparam int ROUNDS_B      = 6;
  localparam int ROUND_START_B = ROUNDS_A - ROUNDS_B;

  // Round indices as they appear on the round bus.
  localparam logic [ROUND_WIDTH-1:0] ROUND_LAST    = ROUND_WIDTH'(ROUNDS_A - 1);
  localparam logic [ROUND_WIDTH-1:0] ROUND_B_FIRST = ROUND_WIDTH'(ROUND_START_B);
  localparam logic [ROUND_WIDTH-1:0] ROUND_B_NEXT  = ROUND_WIDTH'(ROUND_START_B + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_WAIT_AD = 3'd2,
    S_AD      = 3'd3,
    S_WAIT_PT = 3'd4,
    S_PT      = 3'd5,
    S_FINAL   = 3'd6,
    S_DONE    = 3'd7
  } t_fsm_state;

endpackage

// File: rtl/ascon_round_counter.sv
// Round counter for the permutation: loadable, incrementing, flags the final round.
module ascon_round_counter
  import ascon_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_load,
  input  logic [ROUND_WIDTH-1:0] i_load_value,
  input  logic                   i_inc,
  output logic [ROUND_WIDTH-1:0] o_count,
  output logic                   o_last
);

  logic [ROUND_WIDTH-1:0] r_count;

  // Load has priority over increment; the FSM loads on every phase boundary
  // so the count never steps past the final round.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n)  r_count <= '0;
    else if (i_load) r_count <= i_load_value;
    else if (i_inc)  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_last  = (r_count == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm.sv
// Control FSM for the ASCON-128 encryption datapath.
// Optional feature macro: ASCON_FSM_ABORT_EN adds i_abort (cancel a message).
//
// Block handshake: a block is transferred in the cycle where both
// i_block_valid and o_block_ready are high; i_block_last is sampled only in
// that cycle. o_block_ready depends on state alone, never on i_block_valid.
module ascon_fsm
  import ascon_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset_n,
`ifdef ASCON_FSM_ABORT_EN
  input  logic                   i_abort,
`endif
  input  logic                   i_start,
  input  logic                   i_has_ad,
  input  logic                   i_block_valid,
  input  logic                   i_block_last,
  output logic                   o_block_ready,
  output logic [ROUND_WIDTH-1:0] o_round,
  output logic                   o_enable_state,
  output logic                   o_select_init,
  output logic                   o_enable_xor_data,
  output logic                   o_enable_xor_key_begin,
  output logic                   o_enable_xor_key_end,
  output logic                   o_enable_xor_lsb,
  output logic                   o_enable_cipher,
  output logic                   o_enable_tag,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [2:0]             o_dbg_state
);

  t_fsm_state             r_state;
  t_fsm_state             w_next;
  logic                   r_has_ad;
  logic                   r_last;
  logic                   w_load;
  logic [ROUND_WIDTH-1:0] w_load_value;
  logic                   w_inc;
  logic [ROUND_WIDTH-1:0] w_count;
  logic                   w_count_last;
  logic                   w_abort;
  logic                   w_start;
  logic                   w_wait;
  logic                   w_accept;

`ifdef ASCON_FSM_ABORT_EN
  assign w_abort = i_abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // A start seen while reset is low must not leak datapath enables.
  assign w_start  = i_start && i_reset_n && (r_state == S_IDLE);
  assign w_wait   = !w_abort && ((r_state == S_WAIT_AD) || (r_state == S_WAIT_PT));
  assign w_accept = w_wait && i_block_valid;

  assign o_block_ready = w_wait;
  assign o_busy        = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

  ascon_round_counter u_counter (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_inc        (w_inc),
    .o_count      (w_count),
    .o_last       (w_count_last)
  );

  // State register plus the per-message flags captured at start and accept.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_has_ad <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start)  r_has_ad <= i_has_ad;
      if (w_accept) r_last   <= i_block_last;
    end
  end

  // Next-state, counter control and Moore-decoded datapath enables.
  always_comb begin
    w_next                 = r_state;
    w_load                 = 1'b0;
    w_load_value           = '0;
    w_inc                  = 1'b0;
    o_round                = '0;
    o_enable_state         = 1'b0;
    o_select_init          = 1'b0;
    o_enable_xor_data      = 1'b0;
    o_enable_xor_key_begin = 1'b0;
    o_enable_xor_key_end   = 1'b0;
    o_enable_xor_lsb       = 1'b0;
    o_enable_cipher        = 1'b0;
    o_enable_tag           = 1'b0;
    o_done                 = 1'b0;

    if (w_abort) begin
      w_next = S_IDLE;
      w_load = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            o_select_init  = 1'b1;
            o_enable_state = 1'b1;
            w_load         = 1'b1;
            w_next         = S_INIT;
          end
        end
        S_INIT: begin
          o_enable_state = 1'b1;
          o_round        = w_count;
          if (w_count_last) begin
            o_enable_xor_key_end = 1'b1;
            o_enable_xor_lsb     = !r_has_ad;
            w_load               = 1'b1;
            w_next               = r_has_ad ? S_WAIT_AD : S_WAIT_PT;
          end else begin
            w_inc = 1'b1;
          end
        end
        S_WAIT_AD: begin
          if (w_accept) begin
            o_enable_state    = 1'b1;
            o_enable_xor_data = 1'b1;
            o_round           = ROUND_B_FIRST;
            w_load            = 1'b1;
            w_load_value      = ROUND_B_NEXT;
            w_next            = S_AD;
          end
        end
        S_AD: begin
          o_enable_state = 1'b1;
          o_round        = w_count;
          if (w_count_last) begin
            o_enable_xor_lsb = r_last;
            w_load           = 1'b1;
            w_next           = r_last ? S_WAIT_PT : S_WAIT_AD;
          end else begin
            w_inc = 1'b1;
          end
        end
        S_WAIT_PT: begin
          if (w_accept) begin
            o_enable_state    = 1'b1;
            o_enable_xor_data = 1'b1;
            o_enable_cipher   = 1'b1;
            w_load            = 1'b1;
            if (i_block_last) begin
              // Last plaintext block starts finalisation at round 0 directly.
              o_enable_xor_key_begin = 1'b1;
              o_round                = '0;
              w_load_value           = ROUND_WIDTH'(1);
              w_next                 = S_FINAL;
            end else begin
              o_round      = ROUND_B_FIRST;
              w_load_value = ROUND_B_NEXT;
              w_next       = S_PT;
            end
          end
        end
        S_PT: begin
          o_enable_state = 1'b1;
          o_round        = w_count;
          if (w_count_last) begin
            w_load = 1'b1;
            w_next = S_WAIT_PT;
          end else begin
            w_inc = 1'b1;
          end
        end
        S_FINAL: begin
          o_enable_state = 1'b1;
          o_round        = w_count;
          if (w_count_last) begin
            o_enable_xor_key_end = 1'b1;
            o_enable_tag         = 1'b1;
            w_load               = 1'b1;
            w_next               = S_DONE;
          end else begin
            w_inc = 1'b1;
          end
        end
        S_DONE: begin
          o_done = 1'b1;
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
          w_load = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_fsm.sv
// Self-checking bench for ascon_fsm: directed messages, expected control
// vectors queued at issue time and compared by an independent monitor.
module tb_ascon_fsm;
  import ascon_pkg::*;

  localparam int W = 13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_reset_n;
  logic       i_start;
  logic       i_has_ad;
  logic       i_block_valid;
  logic       i_block_last;
`ifdef ASCON_FSM_ABORT_EN
  logic       i_abort;
`endif
  logic       o_block_ready;
  logic [3:0] o_round;
  logic       o_enable_state;
  logic       o_select_init;
  logic       o_enable_xor_data;
  logic       o_enable_xor_key_begin;
  logic       o_enable_xor_key_end;
  logic       o_enable_xor_lsb;
  logic       o_enable_cipher;
  logic       o_enable_tag;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_dbg_state;

  ascon_fsm dut (
    .i_clock                (clk),
    .i_reset_n              (i_reset_n),
`ifdef ASCON_FSM_ABORT_EN
    .i_abort                (i_abort),
`endif
    .i_start                (i_start),
    .i_has_ad               (i_has_ad),
    .i_block_valid          (i_block_valid),
    .i_block_last           (i_block_last),
    .o_block_ready          (o_block_ready),
    .o_round                (o_round),
    .o_enable_state         (o_enable_state),
    .o_select_init          (o_select_init),
    .o_enable_xor_data      (o_enable_xor_data),
    .o_enable_xor_key_begin (o_enable_xor_key_begin),
    .o_enable_xor_key_end   (o_enable_xor_key_end),
    .o_enable_xor_lsb       (o_enable_xor_lsb),
    .o_enable_cipher        (o_enable_cipher),
    .o_enable_tag           (o_enable_tag),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_dbg_state            (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  wire [W-1:0] w_obs = {o_done, o_select_init, o_enable_state, o_round,
                        o_enable_xor_data, o_enable_xor_key_begin,
                        o_enable_xor_key_end, o_enable_xor_lsb,
                        o_enable_cipher, o_enable_tag};
  wire w_event = o_done | o_select_init | o_enable_state | o_enable_xor_data |
                 o_enable_xor_key_begin | o_enable_xor_key_end |
                 o_enable_xor_lsb | o_enable_cipher | o_enable_tag;

  function automatic logic [W-1:0] mk(input logic dn, input logic sel,
                                      input logic es, input int rnd,
                                      input logic xd, input logic kb,
                                      input logic ke, input logic lsb,
                                      input logic ci, input logic tg);
    logic [3:0] r4;
    r4 = rnd[3:0];
    return {dn, sel, es, r4, xd, kb, ke, lsb, ci, tg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with any control activity consumes one expected vector.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (w_event === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", w_obs);
        end else begin
          e = exp_q.pop_front();
          check("ctrl_vector", w_obs, e);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- expected-vector builders ----------------
  task automatic push_start(input bit has_ad, input int upto);
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r <= upto; r++)
      exp_q.push_back(mk(0, 0, 1, r, 0, 0, r == 11, (r == 11) && !has_ad, 0, 0));
  endtask

  task automatic push_b_rounds(input bit lsb_at_end);
    for (int r = 7; r <= 11; r++)
      exp_q.push_back(mk(0, 0, 1, r, 0, 0, 0, (r == 11) && lsb_at_end, 0, 0));
  endtask

  task automatic push_final(input int upto);
    for (int r = 1; r <= upto; r++)
      exp_q.push_back(mk(0, 0, 1, r, 0, 0, r == 11, 0, 0, r == 11));
    if (upto == 11) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input bit has_ad);
    int n;
    push_start(has_ad, 11);
    i_start  = 1'b1;
    i_has_ad = has_ad;
    tick();
    i_start  = 1'b0;
    i_has_ad = 1'b0;
    n = 1;
    while (!o_block_ready && n < 100) begin tick(); n++; end
    check("init_latency", n, 13);
  endtask

  // Issues one block while o_block_ready is high and measures the time until
  // the FSM is ready again (or idle, for the last plaintext block).
  task automatic send_block(input bit is_ad, input bit last, input bit poke_start);
    int n;
    if (is_ad) begin
      exp_q.push_back(mk(0, 0, 1, 6, 1, 0, 0, 0, 0, 0));
      push_b_rounds(last);
    end else if (!last) begin
      exp_q.push_back(mk(0, 0, 1, 6, 1, 0, 0, 0, 1, 0));
      push_b_rounds(1'b0);
    end else begin
      exp_q.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 1, 0));
      push_final(11);
    end
    check("ready_before_accept", o_block_ready, 1);
    i_block_valid = 1'b1;
    i_block_last  = last;
    tick();
    i_block_valid = 1'b0;
    i_block_last  = 1'($urandom_range(0, 1));
    i_start       = poke_start;
    n = 1;
    if (!is_ad && last) begin
      while (o_busy && n < 100) begin tick(); n++; end
      check("final_latency", n, 13);
    end else begin
      while (!o_block_ready && n < 100) begin tick(); n++; end
      check("block_latency", n, 6);
    end
    i_start = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    i_reset_n     = 1'b0;
    i_start       = 1'b1;  // reset must win over start
    i_has_ad      = 1'b1;
    i_block_valid = 1'b0;
    i_block_last  = 1'b0;
`ifdef ASCON_FSM_ABORT_EN
    i_abort       = 1'b0;
`endif
    repeat (3) tick();
    check("reset_state", o_dbg_state, S_IDLE);
    check("reset_outputs", {o_busy, o_block_ready, w_obs}, 0);
    i_start   = 1'b0;
    i_has_ad  = 1'b0;
    i_reset_n = 1'b1;
    tick();
    check("idle_after_reset", {o_busy, o_block_ready}, 0);

    // Message A: no AD, one last plaintext block after a short idle gap.
    start_msg(1'b0);
    repeat ($urandom_range(1, 3)) tick();
    send_block(1'b0, 1'b1, 1'b0);
    check("idle_after_msg_a", o_busy, 0);

    // Message B: two AD blocks (valid held through the first block's rounds),
    // two PT blocks, start poked during the first PT rounds.
    start_msg(1'b1);
    exp_q.push_back(mk(0, 0, 1, 6, 1, 0, 0, 0, 0, 0));
    push_b_rounds(1'b0);
    i_block_valid = 1'b1;
    i_block_last  = 1'b0;
    begin
      int n;
      tick();
      n = 1;
      while (!o_block_ready && n < 100) begin tick(); n++; end
      check("held_valid_latency", n, 6);
    end
    i_block_valid = 1'b0;
    send_block(1'b1, 1'b1, 1'b0);
    send_block(1'b0, 1'b0, 1'b1);
    send_block(1'b0, 1'b1, 1'b0);
    check("idle_after_msg_b", o_busy, 0);

    // Reset during INIT round 5 with valid asserted (never ready, never accepted).
    push_start(1'b0, 5);
    i_start = 1'b1;
    tick();
    i_start       = 1'b0;
    i_block_valid = 1'b1;
    repeat (5) tick();
    check("mid_init_round", o_round, 5);
    i_reset_n = 1'b0;
    tick();
    check("mid_reset_state", o_dbg_state, S_IDLE);
    check("mid_reset_outputs", {o_busy, o_block_ready, w_obs}, 0);
    i_reset_n     = 1'b1;
    i_block_valid = 1'b0;
    tick();

    // Message C: recovers cleanly after the reset.
    start_msg(1'b1);
    send_block(1'b1, 1'b1, 1'b0);
    send_block(1'b0, 1'b1, 1'b0);

`ifdef ASCON_FSM_ABORT_EN
    // Abort in FINAL round 4: no tag, no done.
    start_msg(1'b0);
    exp_q.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 1, 0));
    push_final(3);
    i_block_valid = 1'b1;
    i_block_last  = 1'b1;
    tick();
    i_block_valid = 1'b0;
    i_block_last  = 1'b0;
    repeat (3) tick();
    check("abort_round", o_round, 4);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_idle", {o_busy, o_dbg_state}, 0);
    repeat (16) tick();
`endif

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
